// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32 mini core multi-cycle control path:
// controller state encoding, major opcodes and datapath select codes.
package riscv_pkg;

  typedef enum logic [3:0] {
    RESET,
    FETCH,
    DECODE,
    MEM_ADDR,
    MEM_READ,
    MEM_WB,
    MEM_WRITE,
    EXECUTE,
    ALU_WB,
    BRANCH,
    TRAP
  } ctrl_state_t;

  // Major opcodes (IR[6:0]) handled by the controller.
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // ALUOp codes consumed by the ALU control decoder.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU B-operand select codes.
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle controller and the datapath:
// opcode / memory-ready inputs and every enable and mux select it drives.
interface multicycle_control_if #(
  parameter int CNT_W = 32
);

  logic [6:0]       opcode;
  logic             mem_ready;
  logic [1:0]       ALUOp;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic             IorD;
  logic             MemRead;
  logic             MemWrite;
  logic             IRWrite;
  logic             PCWrite;
  logic             PCWriteCond;
  logic             PCSource;
  logic             RegWrite;
  logic             MemtoReg;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  // Controller side.
  modport slave (
    input  opcode, mem_ready,
    output ALUOp, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite, IRWrite,
           PCWrite, PCWriteCond, PCSource, RegWrite, MemtoReg, illegal,
           retired
  );

  // Datapath side.
  modport master (
    output opcode, mem_ready,
    input  ALUOp, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite, IRWrite,
           PCWrite, PCWriteCond, PCSource, RegWrite, MemtoReg, illegal,
           retired
  );

endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM for the RV32 mini core. Moore decode of the
// state drives the shared-memory datapath; FETCH additionally gates IRWrite
// and PCWrite with mem_ready. Illegal opcodes park the FSM in TRAP, and a
// wrapping counter tracks retired instructions.
module multicycle_control
  import riscv_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_control_if.slave  ctrl
);

  ctrl_state_t      state_q, state_d;
  logic [CNT_W-1:0] retired_q;
  logic             retire;

  // State register; reset parks the FSM in RESET with all outputs low.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RESET;
    else        state_q <= state_d;
  end

  // Next-state logic; mem_ready and opcode are looked at only where needed.
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RESET:     state_d = FETCH;
      FETCH:     if (ctrl.mem_ready) state_d = DECODE;
      DECODE: begin
        case (ctrl.opcode)
          OP_LOAD, OP_STORE: state_d = MEM_ADDR;
          OP_RTYPE:          state_d = EXECUTE;
          OP_BRANCH:         state_d = BRANCH;
          default:           state_d = TRAP;
        endcase
      end
      MEM_ADDR:  state_d = (ctrl.opcode == OP_LOAD) ? MEM_READ : MEM_WRITE;
      MEM_READ:  if (ctrl.mem_ready) state_d = MEM_WB;
      MEM_WB:    state_d = FETCH;
      MEM_WRITE: if (ctrl.mem_ready) state_d = FETCH;
      EXECUTE:   state_d = ALU_WB;
      ALU_WB:    state_d = FETCH;
      BRANCH:    state_d = FETCH;
      TRAP:      state_d = TRAP;
      default:   state_d = RESET;
    endcase
  end

  // Moore output decode; anything not set for a state stays 0.
  always_comb begin
    ctrl.ALUOp       = ALUOP_ADD;
    ctrl.ALUSrcA     = 1'b0;
    ctrl.ALUSrcB     = SRCB_RS2;
    ctrl.IorD        = 1'b0;
    ctrl.MemRead     = 1'b0;
    ctrl.MemWrite    = 1'b0;
    ctrl.IRWrite     = 1'b0;
    ctrl.PCWrite     = 1'b0;
    ctrl.PCWriteCond = 1'b0;
    ctrl.PCSource    = 1'b0;
    ctrl.RegWrite    = 1'b0;
    ctrl.MemtoReg    = 1'b0;
    ctrl.illegal     = 1'b0;
    unique case (state_q)
      FETCH: begin
        ctrl.MemRead = 1'b1;
        ctrl.ALUSrcB = SRCB_FOUR;
        // IR and PC+4 are captured only on the cycle memory delivers.
        ctrl.IRWrite = ctrl.mem_ready;
        ctrl.PCWrite = ctrl.mem_ready;
      end
      DECODE:    ctrl.ALUSrcB = SRCB_BOFF;
      MEM_ADDR: begin
        ctrl.ALUSrcA = 1'b1;
        ctrl.ALUSrcB = SRCB_IMM;
      end
      MEM_READ: begin
        ctrl.MemRead = 1'b1;
        ctrl.IorD    = 1'b1;
      end
      MEM_WB: begin
        ctrl.RegWrite = 1'b1;
        ctrl.MemtoReg = 1'b1;
      end
      MEM_WRITE: begin
        ctrl.MemWrite = 1'b1;
        ctrl.IorD     = 1'b1;
      end
      EXECUTE: begin
        ctrl.ALUSrcA = 1'b1;
        ctrl.ALUOp   = ALUOP_FUNCT;
      end
      ALU_WB:    ctrl.RegWrite = 1'b1;
      BRANCH: begin
        ctrl.ALUSrcA     = 1'b1;
        ctrl.ALUOp       = ALUOP_SUB;
        ctrl.PCWriteCond = 1'b1;
        ctrl.PCSource    = 1'b1;
      end
      TRAP:      ctrl.illegal = 1'b1;
      default:   ;
    endcase
  end

  // An instruction retires on the edge leaving its final state.
  assign retire = (state_q == MEM_WB) || (state_q == ALU_WB) ||
                  (state_q == BRANCH) ||
                  ((state_q == MEM_WRITE) && ctrl.mem_ready);

  // Retired-instruction counter, wrapping modulo 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      retired_q <= '0;
    else if (retire) retired_q <= retired_q + CNT_W'(1);
  end

  assign ctrl.retired = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: the stimulus process walks
// hand-written state sequences and queues the outputs each cycle must show;
// a monitor pops and compares them on the falling edge.
module tb_multicycle_control;

  localparam int CNT_W = 4;

  typedef enum {
    T_RESET, T_FETCH, T_DECODE, T_MEM_ADDR, T_MEM_READ, T_MEM_WB,
    T_MEM_WRITE, T_EXECUTE, T_ALU_WB, T_BRANCH, T_TRAP
  } tst_e;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_source;
    logic       reg_write;
    logic       mem_to_reg;
    logic       illegal;
  } outs_t;

  typedef struct {
    string            name;
    outs_t            o;
    logic [CNT_W-1:0] ret;
  } exp_t;

  localparam logic [6:0] R_OP   = 7'b0110011;
  localparam logic [6:0] LW_OP  = 7'b0000011;
  localparam logic [6:0] SW_OP  = 7'b0100011;
  localparam logic [6:0] BEQ_OP = 7'b1100011;
  localparam logic [6:0] BAD_OP = 7'b0010011;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_passed = 0;
  logic [CNT_W-1:0] ret_model = '0;
  exp_t exp_q[$];

  multicycle_control_if #(.CNT_W(CNT_W)) bus ();

  multicycle_control #(.CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ctrl (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_passed++;
    else $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
  endtask

  // Output vector each state must present, straight from the state table.
  function automatic outs_t outs(tst_e s, logic mr);
    outs_t o = '0;
    case (s)
      T_FETCH:     begin o.mem_read = 1'b1; o.alu_src_b = 2'b01;
                         o.ir_write = mr; o.pc_write = mr; end
      T_DECODE:    o.alu_src_b = 2'b11;
      T_MEM_ADDR:  begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
      T_MEM_READ:  begin o.mem_read = 1'b1; o.iord = 1'b1; end
      T_MEM_WB:    begin o.reg_write = 1'b1; o.mem_to_reg = 1'b1; end
      T_MEM_WRITE: begin o.mem_write = 1'b1; o.iord = 1'b1; end
      T_EXECUTE:   begin o.alu_src_a = 1'b1; o.alu_op = 2'b10; end
      T_ALU_WB:    o.reg_write = 1'b1;
      T_BRANCH:    begin o.alu_src_a = 1'b1; o.alu_op = 2'b01;
                         o.pc_write_cond = 1'b1; o.pc_source = 1'b1; end
      T_TRAP:      o.illegal = 1'b1;
      default:     ;
    endcase
    return o;
  endfunction

  // One cycle: drive inputs, queue what this cycle must show, advance.
  task automatic step(input tst_e s, input logic [6:0] op, input logic mr, input string name);
    exp_t e;
    bus.opcode    = op;
    bus.mem_ready = mr;
    e.name = name;
    e.o    = outs(s, mr);
    e.ret  = ret_model;
    exp_q.push_back(e);
    @(posedge clk); #1;
    if (s == T_MEM_WB || s == T_ALU_WB || s == T_BRANCH || (s == T_MEM_WRITE && mr))
      ret_model = ret_model + 1'b1;
  endtask

  // Reset asserted mid-cycle: outputs must drop before the falling edge.
  task automatic reset_mid(input string name);
    exp_t e;
    ret_model = '0;
    e.name = name;
    e.o    = '0;
    e.ret  = '0;
    exp_q.push_back(e);
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    step(T_RESET, R_OP, 1'b1, "reset_release");
  endtask

  // Monitor: compare the DUT against the queued expectation each cycle.
  initial begin
    exp_t  e;
    outs_t a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a.alu_op        = bus.ALUOp;
        a.alu_src_a     = bus.ALUSrcA;
        a.alu_src_b     = bus.ALUSrcB;
        a.iord          = bus.IorD;
        a.mem_read      = bus.MemRead;
        a.mem_write     = bus.MemWrite;
        a.ir_write      = bus.IRWrite;
        a.pc_write      = bus.PCWrite;
        a.pc_write_cond = bus.PCWriteCond;
        a.pc_source     = bus.PCSource;
        a.reg_write     = bus.RegWrite;
        a.mem_to_reg    = bus.MemtoReg;
        a.illegal       = bus.illegal;
        check({e.name, "_outs"}, 64'(a), 64'(e.o));
        check({e.name, "_retired"}, 64'(bus.retired), 64'(e.ret));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks so far %0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n         = 1'b0;
    bus.opcode    = 7'b0;
    bus.mem_ready = 1'b0;
    @(posedge clk); #1;

    // Reset held for 3 cycles, then one RESET cycle before the first FETCH.
    for (int i = 0; i < 3; i++) step(T_RESET, R_OP, 1'b1, "reset_hold");
    release_reset();

    // R-type, zero wait: 4 cycles.
    step(T_FETCH,   R_OP, 1'b1, "r_fetch");
    step(T_DECODE,  R_OP, 1'b1, "r_decode");
    step(T_EXECUTE, R_OP, 1'b1, "r_execute");
    step(T_ALU_WB,  R_OP, 1'b1, "r_alu_wb");

    // Load with two wait cycles in MEM_READ; mem_ready ignored elsewhere.
    step(T_FETCH,    LW_OP, 1'b1, "lw_fetch");
    step(T_DECODE,   LW_OP, 1'b0, "lw_decode");
    step(T_MEM_ADDR, LW_OP, 1'b0, "lw_mem_addr");
    step(T_MEM_READ, LW_OP, 1'b0, "lw_mem_read_w1");
    step(T_MEM_READ, LW_OP, 1'b0, "lw_mem_read_w2");
    step(T_MEM_READ, LW_OP, 1'b1, "lw_mem_read");
    step(T_MEM_WB,   LW_OP, 1'b0, "lw_mem_wb");

    // beq then sw back to back: 7 cycles, two retirements.
    step(T_FETCH,     BEQ_OP, 1'b1, "beq_fetch");
    step(T_DECODE,    BEQ_OP, 1'b1, "beq_decode");
    step(T_BRANCH,    BEQ_OP, 1'b0, "beq_branch");
    step(T_FETCH,     SW_OP,  1'b1, "sw_fetch");
    step(T_DECODE,    SW_OP,  1'b1, "sw_decode");
    step(T_MEM_ADDR,  SW_OP,  1'b1, "sw_mem_addr");
    step(T_MEM_WRITE, SW_OP,  1'b1, "sw_mem_write");

    // Store with a wait cycle in MEM_WRITE; no retire on the waiting edge.
    step(T_FETCH,     SW_OP, 1'b1, "sww_fetch");
    step(T_DECODE,    SW_OP, 1'b1, "sww_decode");
    step(T_MEM_ADDR,  SW_OP, 1'b1, "sww_mem_addr");
    step(T_MEM_WRITE, SW_OP, 1'b0, "sww_mem_write_w");
    step(T_MEM_WRITE, SW_OP, 1'b1, "sww_mem_write");

    // Branches until the 4-bit counter wraps through 0 and on to 1.
    for (int i = 0; i < 12; i++) begin
      step(T_FETCH,  BEQ_OP, 1'b1, "wrap_fetch");
      step(T_DECODE, BEQ_OP, 1'b1, "wrap_decode");
      step(T_BRANCH, BEQ_OP, 1'b1, "wrap_branch");
    end

    // Reset while a load waits in MEM_READ: strobes drop at once.
    step(T_FETCH,    LW_OP, 1'b1, "mid_fetch");
    step(T_DECODE,   LW_OP, 1'b1, "mid_decode");
    step(T_MEM_ADDR, LW_OP, 1'b1, "mid_mem_addr");
    step(T_MEM_READ, LW_OP, 1'b0, "mid_mem_read");
    reset_mid("mid_reset");
    release_reset();
    step(T_FETCH,   R_OP, 1'b1, "post_fetch");
    step(T_DECODE,  R_OP, 1'b1, "post_decode");
    step(T_EXECUTE, R_OP, 1'b1, "post_execute");
    step(T_ALU_WB,  R_OP, 1'b1, "post_alu_wb");

    // Illegal opcode after a fetch wait: TRAP absorbs regardless of inputs.
    step(T_FETCH,  BAD_OP, 1'b0, "ill_fetch_w");
    step(T_FETCH,  BAD_OP, 1'b1, "ill_fetch");
    step(T_DECODE, BAD_OP, 1'b1, "ill_decode");
    for (int i = 0; i < 12; i++)
      step(T_TRAP, (i % 2 == 0) ? R_OP : LW_OP, 1'(i % 3 == 0), "ill_trap");
    reset_mid("ill_reset");
    release_reset();
    step(T_FETCH, R_OP, 1'b0, "ill_refetch");

    @(posedge clk); #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
